// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: captures a 128-bit state on st and substitutes BYTES_PER_CYCLE
// bytes per clock through the forward S-box, then presents the result with a done pulse.
module sub_bytes_iter #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         st,
  input  logic [127:0] data_in,
  output logic [127:0] data_out,
  output logic         busy,
  output logic         done
);

  localparam int N       = 16 / BYTES_PER_CYCLE;
  localparam int CHUNK_W = 8 * BYTES_PER_CYCLE;
  localparam int CW      = (N > 1) ? $clog2(N) : 1;

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_param
    $error("sub_bytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  // Entry 0 is the leftmost byte of the concatenation.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [127:0]         work;
  logic [127:0]         work_next;
  logic [6:0]           off;
  logic [CHUNK_W-1:0]   chunk_in;
  logic [CHUNK_W-1:0]   sub_chunk;

  // Chunk 0 holds byte 0, which sits in the MSBs of the state.
  assign off      = 7'(CHUNK_W) * (7'(N - 1) - 7'(cnt));
  assign chunk_in = work[off +: CHUNK_W];

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    assign sub_chunk[8*g +: 8] = SBOX[chunk_in[8*g +: 8]];
  end

  always_comb begin
    work_next = work;
    work_next[off +: CHUNK_W] = sub_chunk;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      work     <= '0;
      data_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (st) begin
            work  <= data_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          work <= work_next;
          if (cnt == CW'(N - 1)) begin
            data_out <= work_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            cnt      <= '0;
            state    <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed bench for sub_bytes_iter at BYTES_PER_CYCLE = 4, 1 and 16.
module tb_sub_bytes_iter;

  localparam logic [127:0] T1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] T1_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] ZEROS  = 128'h0;
  localparam logic [127:0] S_ZERO = {16{8'h63}};
  localparam logic [127:0] ONES   = {16{8'hff}};
  localparam logic [127:0] S_ONES = {16{8'h16}};
  localparam logic [127:0] ALL53  = {16{8'h53}};
  localparam logic [127:0] S_53   = {16{8'hed}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   st_v = 3'b000;
  logic [127:0] data_in = '0;
  logic [127:0] dout4, dout1, dout16;
  logic         busy4, busy1, busy16;
  logic         done4, done1, done16;

  int           sel = 0;
  logic [127:0] cur_dout;
  logic         cur_busy, cur_done;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sub_bytes_iter #(.BYTES_PER_CYCLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .st(st_v[0]), .data_in(data_in),
    .data_out(dout4), .busy(busy4), .done(done4));

  sub_bytes_iter #(.BYTES_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .st(st_v[1]), .data_in(data_in),
    .data_out(dout1), .busy(busy1), .done(done1));

  sub_bytes_iter #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .st(st_v[2]), .data_in(data_in),
    .data_out(dout16), .busy(busy16), .done(done16));

  always_comb begin
    cur_dout = dout4;
    cur_busy = busy4;
    cur_done = done4;
    case (sel)
      1: begin cur_dout = dout1;  cur_busy = busy1;  cur_done = done1;  end
      2: begin cur_dout = dout16; cur_busy = busy16; cur_done = done16; end
      default: ;
    endcase
  end

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({dout4, dout1, dout16} !== '0) $display("FAIL reset_data_out: got %h %h %h want 0", dout4, dout1, dout16);
    else passed++;
    total++;
    if ({busy4, busy1, busy16, done4, done1, done16} !== 6'b0)
      $display("FAIL reset_flags: got busy=%b%b%b done=%b%b%b want 0", busy4, busy1, busy16, done4, done1, done16);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One block on DUT s (0: B=4 N=4, 1: B=1 N=16, 2: B=16 N=1) with full latency tracking.
  task automatic test_vector(input int s, input logic [127:0] din, input logic [127:0] exp, input string name);
    int n;
    n = (s == 0) ? 4 : (s == 1) ? 16 : 1;
    sel = s;
    @(negedge clk);
    st_v[s] = 1'b1;
    data_in = din;
    @(negedge clk);
    st_v[s] = 1'b0;
    data_in = ~din;
    total++;
    if (cur_busy !== 1'b1 || cur_done !== 1'b0)
      $display("FAIL %s_start: got busy=%b done=%b want busy=1 done=0", name, cur_busy, cur_done);
    else passed++;
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      total++;
      if (cur_busy !== 1'b1 || cur_done !== 1'b0)
        $display("FAIL %s_run%0d: got busy=%b done=%b want busy=1 done=0", name, i, cur_busy, cur_done);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (cur_done !== 1'b1 || cur_busy !== 1'b0 || cur_dout !== exp)
      $display("FAIL %s_done: got done=%b busy=%b data_out=%h want done=1 busy=0 data_out=%h",
               name, cur_done, cur_busy, cur_dout, exp);
    else passed++;
    @(negedge clk);
    total++;
    if (cur_done !== 1'b0 || cur_dout !== exp)
      $display("FAIL %s_hold: got done=%b data_out=%h want done=0 data_out=%h", name, cur_done, cur_dout, exp);
    else passed++;
    sel = 0;
  endtask

  task automatic test_substitution();
    test_vector(0, T1_IN, T1_OUT, "fips_b4");
    test_vector(0, ZEROS, S_ZERO, "zero_b4");
    test_vector(0, ONES,  S_ONES, "ones_b4");
    test_vector(0, ALL53, S_53,   "x53_b4");
  endtask

  task automatic test_ignore_st();
    @(negedge clk);
    st_v[0] = 1'b1;
    data_in = T1_IN;
    @(negedge clk);
    data_in = ONES;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (busy4 !== 1'b1 || done4 !== 1'b0)
        $display("FAIL ignore_st_run%0d: got busy=%b done=%b want busy=1 done=0", i, busy4, done4);
      else passed++;
    end
    st_v[0] = 1'b0;
    @(negedge clk);
    total++;
    if (done4 !== 1'b1 || dout4 !== T1_OUT)
      $display("FAIL ignore_st_done: got done=%b data_out=%h want done=1 data_out=%h", done4, dout4, T1_OUT);
    else passed++;
    repeat (6) @(negedge clk);
    total++;
    if (busy4 !== 1'b0 || dout4 !== T1_OUT)
      $display("FAIL ignore_st_idle: got busy=%b data_out=%h want busy=0 data_out=%h", busy4, dout4, T1_OUT);
    else passed++;
  endtask

  task automatic test_reset_midrun();
    logic saw_done;
    @(negedge clk);
    st_v[0] = 1'b1;
    data_in = ALL53;
    @(negedge clk);
    st_v[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0 || dout4 !== '0)
      $display("FAIL midrun_reset: got busy=%b done=%b data_out=%h want 0 0 0", busy4, done4, dout4);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done4 === 1'b1 || busy4 === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done !== 1'b0 || dout4 !== '0)
      $display("FAIL midrun_no_done: got activity=%b data_out=%h want 0 and 0", saw_done, dout4);
    else passed++;
    test_vector(0, T1_IN, T1_OUT, "after_reset");
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    st_v[0] = 1'b1;
    data_in = T1_IN;
    @(negedge clk);
    st_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (done4 !== 1'b1 || dout4 !== T1_OUT)
      $display("FAIL b2b_first: got done=%b data_out=%h want done=1 data_out=%h", done4, dout4, T1_OUT);
    else passed++;
    st_v[0] = 1'b1;
    data_in = ZEROS;
    @(negedge clk);
    st_v[0] = 1'b0;
    data_in = ONES;
    total++;
    if (busy4 !== 1'b1) $display("FAIL b2b_accept: got busy=%b want 1", busy4);
    else passed++;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      total++;
      if (done4 !== 1'b0 || dout4 !== T1_OUT)
        $display("FAIL b2b_hold%0d: got done=%b data_out=%h want done=0 data_out=%h", i, done4, dout4, T1_OUT);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (done4 !== 1'b1 || dout4 !== S_ZERO)
      $display("FAIL b2b_second: got done=%b data_out=%h want done=1 data_out=%h", done4, dout4, S_ZERO);
    else passed++;
  endtask

  task automatic test_param_variants();
    test_vector(1, T1_IN, T1_OUT, "fips_b1");
    test_vector(1, ZEROS, S_ZERO, "zero_b1");
    test_vector(1, ALL53, S_53,   "x53_b1");
    test_vector(2, T1_IN, T1_OUT, "fips_b16");
    test_vector(2, ONES,  S_ONES, "ones_b16");
    test_vector(2, ALL53, S_53,   "x53_b16");
  endtask

  initial begin
    test_reset();
    test_substitution();
    test_ignore_st();
    test_reset_midrun();
    test_back_to_back();
    test_param_variants();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
